// File: rtl/mem_stage.sv
// MEM pipeline stage: latches one EXE entry, shapes load data from the synchronous
// data SRAM, and presents the WB payload plus the ID bypass.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    // EXE -> MEM handshake and payload
    input  logic        ready_go_exe,
    output logic        allow_in,
    input  logic [31:0] inst_from_exe,
    input  logic [31:0] pc_from_exe,
    input  logic [31:0] alu_result_from_exe,
    input  logic        reg_en_from_exe,
    input  logic        mem_ld_from_exe,
    input  logic [4:0]  dest_from_exe,
    input  logic [2:0]  ld_op_from_exe,
    input  logic [31:0] data_sram_rdata,
    // MEM -> WB handshake and payload
    output logic        ready_go,
    input  logic        WB_allow_in,
    output logic [31:0] inst_mem,
    output logic [31:0] pc_mem,
    output logic [31:0] final_result,
    output logic        reg_en,
    output logic [4:0]  dest,
    output logic        valid,
    // ID bypass
    output logic [31:0] forward_data_mem,
    output logic        forward_en_mem
);

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    logic        valid_q,      valid_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic        reg_en_q,     reg_en_d;
    logic        mem_ld_q,     mem_ld_d;
    logic [2:0]  ld_op_q,      ld_op_d;
    logic [4:0]  dest_q,       dest_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;
    logic        hold_vld_q,   hold_vld_d;

    logic        leave;
    logic        accept;
    logic [31:0] raw;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    assign ready_go = valid_q;
    assign leave    = ready_go & WB_allow_in;
    assign allow_in = ~valid_q | leave;
    assign accept   = ready_go_exe & allow_in;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        valid_d      = valid_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        alu_result_d = alu_result_q;
        reg_en_d     = reg_en_q;
        mem_ld_d     = mem_ld_q;
        ld_op_d      = ld_op_q;
        dest_d       = dest_q;
        rdata_hold_d = rdata_hold_q;
        hold_vld_d   = hold_vld_q;

        if (accept) begin
            valid_d      = 1'b1;
            inst_d       = inst_from_exe;
            pc_d         = pc_from_exe;
            alu_result_d = alu_result_from_exe;
            reg_en_d     = reg_en_from_exe;
            mem_ld_d     = mem_ld_from_exe;
            ld_op_d      = ld_op_from_exe;
            dest_d       = dest_from_exe;
        end else if (leave) begin
            valid_d = 1'b0;
        end

        // SRAM data is only valid in the first MEM cycle, so a stalled load keeps a copy.
        if (accept || leave) begin
            hold_vld_d = 1'b0;
        end else if (valid_q && mem_ld_q && !hold_vld_q && !WB_allow_in) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_comb begin
        raw = hold_vld_q ? rdata_hold_q : data_sram_rdata;

        case (alu_result_q[1:0])
            2'd0:    byte_lane = raw[7:0];
            2'd1:    byte_lane = raw[15:8];
            2'd2:    byte_lane = raw[23:16];
            default: byte_lane = raw[31:24];
        endcase
        half_lane = alu_result_q[1] ? raw[31:16] : raw[15:0];

        case (ld_op_q)
            LD_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            LD_H:    load_data = {{16{half_lane[15]}}, half_lane};
            LD_BU:   load_data = {24'b0, byte_lane};
            LD_HU:   load_data = {16'b0, half_lane};
            LD_W:    load_data = raw;
            default: load_data = raw;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; the payload is reset too so
    // nothing from before a reset can reach the outputs afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            inst_q       <= '0;
            pc_q         <= '0;
            alu_result_q <= '0;
            reg_en_q     <= 1'b0;
            mem_ld_q     <= 1'b0;
            ld_op_q      <= '0;
            dest_q       <= '0;
            rdata_hold_q <= '0;
            hold_vld_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            alu_result_q <= alu_result_d;
            reg_en_q     <= reg_en_d;
            mem_ld_q     <= mem_ld_d;
            ld_op_q      <= ld_op_d;
            dest_q       <= dest_d;
            rdata_hold_q <= rdata_hold_d;
            hold_vld_q   <= hold_vld_d;
        end
    end

    assign valid            = valid_q;
    assign inst_mem         = inst_q;
    assign pc_mem           = pc_q;
    assign dest             = dest_q;
    assign final_result     = mem_ld_q ? load_data : alu_result_q;
    assign reg_en           = reg_en_q & valid_q;
    assign forward_en_mem   = valid_q & reg_en_q & (dest_q != 5'd0);
    assign forward_data_mem = final_result;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports ready_go_exe input 1 and allow_in output 1; together they form the EXE->MEM handshake.
REQ-004 SHALL have inputs inst_from_exe 32, pc_from_exe 32, alu_result_from_exe 32 (result or load address), reg_en_from_exe 1, mem_ld_from_exe 1, dest_from_exe 5.
REQ-005 SHALL have input ld_op_from_exe 3: 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu; other codes behave as ld.w.
REQ-006 SHALL have input data_sram_rdata 32: synchronous SRAM read data, valid in the first cycle an entry sits in MEM.
REQ-007 SHALL have output ready_go 1 and input WB_allow_in 1; together they form the MEM->WB handshake.
REQ-008 SHALL have outputs inst_mem 32, pc_mem 32, final_result 32, reg_en 1, dest 5 and valid 1.
REQ-009 SHALL have outputs forward_data_mem 32 and forward_en_mem 1 for the ID bypass.

Function
REQ-010 SHALL set valid<=1 on accept (ready_go_exe & allow_in); otherwise SHALL set valid<=0 when ready_go & WB_allow_in; otherwise valid SHALL hold.
REQ-011 SHALL drive allow_in = ~valid | (ready_go & WB_allow_in); simultaneous leave+accept in one cycle SHALL keep valid=1 with the new payload.
REQ-012 SHALL drive ready_go = valid; the MEM stage adds no wait cycles.
REQ-013 SHALL latch inst, pc, alu_result, reg_en, mem_ld, ld_op and dest only on accept; the payload SHALL hold otherwise.
REQ-014 SHALL keep a hold buffer (rdata_hold 32, hold_vld 1): on valid & mem_ld & ~hold_vld & ~WB_allow_in, capture data_sram_rdata and set hold_vld.
REQ-015 SHALL clear hold_vld on leave (ready_go & WB_allow_in) or on accept; accept SHALL take priority over capture in the same cycle.
REQ-016 SHALL use raw = hold_vld ? rdata_hold : data_sram_rdata, so a load stalled N cycles returns its first-cycle data.
REQ-017 SHALL select the load lane with addr[1:0] = latched alu_result[1:0]: byte lane = raw[8*addr+7 : 8*addr]; half lane = raw[31:16] if addr[1] else raw[15:0].
REQ-018 SHALL sign-extend the lane to 32 bits for ld.b/ld.h, zero-extend for ld.bu/ld.hu, and pass raw unchanged for ld.w (addr ignored).
REQ-019 SHALL drive final_result = mem_ld ? load_data : latched alu_result.
REQ-020 SHALL drive reg_en output = latched reg_en & valid.
REQ-021 SHALL drive forward_en_mem = valid & reg_en & (dest != 0), and forward_data_mem = final_result, loads included.
REQ-022 SHALL drive inst_mem, pc_mem and dest directly from the latched payload.

Reset
REQ-023 SHALL, on reset assertion and independent of clk, clear valid, hold_vld, rdata_hold and every payload register to 0.
REQ-024 SHALL therefore present after reset: allow_in=1, ready_go=0, reg_en=0, forward_en_mem=0, final_result=0, inst_mem=pc_mem=0, dest=0.
REQ-025 SHALL discard any in-flight entry and buffered data when reset asserts mid-operation; no output may reflect pre-reset state after release.

Verification
REQ-026 Bench SHALL cover non-load pass-through: alu_result=0x1234_5678, reg_en=1, dest=5, WB_allow_in=1 -> next cycle valid=1, final_result=0x1234_5678, forward_en_mem=1.
REQ-027 Bench SHALL cover ld.b sign-extension: addr=0x1003, rdata=0x80FF_0011 -> final_result=0xFFFF_FF80.
REQ-028 Bench SHALL cover ld.hu and ld.h: ld.hu with addr=0x1002, rdata=0x9ABC_0000 -> 0x0000_9ABC; ld.h with the same inputs -> 0xFFFF_9ABC.
REQ-029 Bench SHALL cover a stalled load: ld.w, rdata=0xDEAD_BEEF in the first MEM cycle, WB_allow_in=0 for 3 cycles while rdata changes to 0x0 -> final_result stays 0xDEAD_BEEF and allow_in=0 throughout; entry leaves in cycle 4.
REQ-030 Bench SHALL cover back-to-back flow: accept and leave in the same cycle -> valid stays 1, payload switches to the new entry, hold_vld=0.
REQ-031 Bench SHALL cover async reset: reset asserted between clock edges with valid=1 and hold_vld=1 -> valid, hold_vld, reg_en and forward_en_mem read 0 immediately, before the next edge.
